// File: rtl/sbox_gen_ctrl_if.sv
// Handshake bundle between the S-box sequencer, the chaotic-map generator and the
// S-box builder. The controller drives it through "master"; the generator/builder side uses "slave".
interface sbox_gen_ctrl_if #(
    parameter int CHAOS_W   = 32,
    parameter int BIT_WIDTH = 8
);
    logic [CHAOS_W-1:0]   chaos_seed;
    logic                 chaos_load;
    logic                 chaos_req;
    logic                 chaos_valid;
    logic [CHAOS_W-1:0]   chaos_data;
    logic                 sbox_clr_n;
    logic                 sbox_tvalid;
    logic [BIT_WIDTH-1:0] sbox_V;
    logic                 done_sbox;

    modport master (
        output chaos_seed,
        output chaos_load,
        output chaos_req,
        input  chaos_valid,
        input  chaos_data,
        output sbox_clr_n,
        output sbox_tvalid,
        output sbox_V,
        input  done_sbox
    );

    modport slave (
        input  chaos_seed,
        input  chaos_load,
        input  chaos_req,
        output chaos_valid,
        output chaos_data,
        input  sbox_clr_n,
        input  sbox_tvalid,
        input  sbox_V,
        output done_sbox
    );
endinterface

// File: rtl/sbox_gen_ctrl.sv
// Sequencer for the chaos-driven S-box builder: clear, seed, warm up the generator,
// then stream folded samples into the builder until it is full or the attempt limit is hit.
module sbox_gen_ctrl #(
    parameter int CHAOS_W      = 32,
    parameter int BIT_WIDTH    = 8,
    parameter int WARMUP       = 64,
    parameter int MAX_ATTEMPTS = 4096,
    parameter int ATT_W        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CHAOS_W-1:0] seed_in,
    sbox_gen_ctrl_if.master    bus,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ATT_W-1:0]   attempts
);
    localparam int                LANES     = CHAOS_W / BIT_WIDTH;
    localparam int                WARM_W    = $clog2(WARMUP + 2);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [ATT_W-1:0]  MAX_ATT   = ATT_W'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WARM,
        ST_GEN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t               state_reg, state_next;
    logic                 clr_cnt_reg, clr_cnt_next;
    logic [WARM_W-1:0]    warm_cnt_reg, warm_cnt_next;
    logic [ATT_W-1:0]     attempts_reg, attempts_next;
    logic [CHAOS_W-1:0]   seed_reg, seed_next;
    logic [BIT_WIDTH-1:0] v_reg, v_next;
    logic                 tvalid_reg, tvalid_next;
    logic                 load_reg, load_next;
    logic                 req_reg;
    logic                 clr_n_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic                 start_ok;

    logic [BIT_WIDTH-1:0] lane [LANES];
    logic [BIT_WIDTH-1:0] fold;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane[gi] = bus.chaos_data[gi*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    always_comb begin
        fold = '0;
        for (int i = 0; i < LANES; i++) begin
            fold = fold ^ lane[i];
        end
    end

    assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                                (state_reg == ST_ERR));

    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        warm_cnt_next = warm_cnt_reg;
        attempts_next = attempts_reg;
        seed_next     = seed_reg;
        v_next        = v_reg;
        tvalid_next   = 1'b0;
        load_next     = 1'b0;

        if (abort) begin
            state_next = ST_IDLE;
        end else if (start_ok) begin
            state_next    = ST_CLEAR;
            seed_next     = seed_in;
            attempts_next = '0;
            warm_cnt_next = '0;
            clr_cnt_next  = 1'b0;
            load_next     = 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    if (clr_cnt_reg) begin
                        state_next = (WARMUP == 0) ? ST_GEN : ST_WARM;
                    end else begin
                        clr_cnt_next = 1'b1;
                    end
                end
                ST_WARM: begin
                    if (bus.chaos_valid) begin
                        if (warm_cnt_reg == WARM_LAST) begin
                            state_next = ST_GEN;
                        end else begin
                            warm_cnt_next = warm_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_GEN: begin
                    // A full builder beats the limit; a sample arriving with done_sbox is dropped.
                    // At the limit, wait for the last tvalid to be judged before giving up.
                    if (bus.done_sbox) begin
                        state_next = ST_DONE;
                    end else if ((attempts_reg == MAX_ATT) && !tvalid_reg) begin
                        state_next = ST_ERR;
                    end else if (bus.chaos_valid && (attempts_reg != MAX_ATT)) begin
                        tvalid_next   = 1'b1;
                        v_next        = fold;
                        attempts_next = attempts_reg + 1'b1;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERR: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            clr_cnt_reg  <= 1'b0;
            warm_cnt_reg <= '0;
            attempts_reg <= '0;
            seed_reg     <= '0;
            v_reg        <= '0;
            tvalid_reg   <= 1'b0;
            load_reg     <= 1'b0;
            req_reg      <= 1'b0;
            clr_n_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            warm_cnt_reg <= warm_cnt_next;
            attempts_reg <= attempts_next;
            seed_reg     <= seed_next;
            v_reg        <= v_next;
            tvalid_reg   <= tvalid_next;
            load_reg     <= load_next;
            // Status and control levels are decoded from the next state so they are flop outputs.
            req_reg      <= (state_next == ST_WARM) || (state_next == ST_GEN);
            clr_n_reg    <= (state_next != ST_CLEAR);
            busy_reg     <= (state_next == ST_CLEAR) || (state_next == ST_WARM) ||
                            (state_next == ST_GEN);
            done_reg     <= (state_next == ST_DONE);
            err_reg      <= (state_next == ST_ERR);
        end
    end

    assign bus.chaos_seed  = seed_reg;
    assign bus.chaos_load  = load_reg;
    assign bus.chaos_req   = req_reg;
    assign bus.sbox_clr_n  = clr_n_reg;
    assign bus.sbox_tvalid = tvalid_reg;
    assign bus.sbox_V      = v_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign err             = err_reg;
    assign attempts        = attempts_reg;
endmodule

// File: tb/tb_sbox_gen_ctrl.sv
// Directed bench for sbox_gen_ctrl with a behavioural chaotic generator and S-box builder.
module tb_sbox_gen_ctrl;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] seed_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] attempts;

    int tests = 0;
    int fails = 0;

    sbox_gen_ctrl_if #(.CHAOS_W(32), .BIT_WIDTH(8)) bus ();

    sbox_gen_ctrl #(
        .CHAOS_W(32), .BIT_WIDTH(8), .WARMUP(64), .MAX_ATTEMPTS(300), .ATT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .seed_in(seed_in),
        .bus(bus), .busy(busy), .done(done), .err(err), .attempts(attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator model: byte lanes {r, r^p, 3C, 3C} fold to p by construction.
    int          gen_mode   = 0;
    int          gen_period = 1;
    logic        gen_valid;
    logic [31:0] gen_data;
    logic [7:0]  cur_p;
    logic [7:0]  seed_b;
    int unsigned gen_k;
    int          gen_ph;

    function automatic logic [7:0] p_of(input int unsigned k, input logic [7:0] sb, input int mode);
        if (mode == 1) return 8'h77;
        return 8'(k * 167 + 32'(sb));
    endfunction

    function automatic logic [31:0] data_of(input int unsigned k, input logic [7:0] p);
        logic [7:0] r;
        r = 8'(k * 29 + 5);
        return {r, r ^ p, 8'h3C, 8'h3C};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_valid <= 1'b0; gen_data <= '0; cur_p <= '0; gen_k <= 0; gen_ph <= 0; seed_b <= '0;
        end else if (bus.chaos_load) begin
            seed_b <= bus.chaos_seed[7:0]; gen_k <= 0; gen_ph <= 0; gen_valid <= 1'b0;
        end else if (bus.chaos_req && (gen_ph == 0)) begin
            gen_valid <= 1'b1;
            cur_p     <= p_of(gen_k, seed_b, gen_mode);
            gen_data  <= data_of(gen_k, p_of(gen_k, seed_b, gen_mode));
            gen_k     <= gen_k + 1;
            gen_ph    <= gen_period - 1;
        end else begin
            gen_valid <= 1'b0;
            if (gen_ph != 0) gen_ph <= gen_ph - 1;
        end
    end
    assign bus.chaos_valid = gen_valid;
    assign bus.chaos_data  = gen_data;

    // Builder model: accepts first occurrences, full one cycle after the 256th accept.
    logic [255:0] seen;
    int           fill;
    logic         full;
    always @(posedge clk) begin
        if (!bus.sbox_clr_n) begin
            seen <= '0; fill <= 0; full <= 1'b0;
        end else if (bus.sbox_tvalid && !seen[bus.sbox_V]) begin
            seen[bus.sbox_V] <= 1'b1;
            fill <= fill + 1;
            if (fill == 255) full <= 1'b1;
        end
    end
    assign bus.done_sbox = full;

    // Cumulative stream monitor: every tvalid must follow a valid and carry its fold.
    int   tv_total = 0;
    int   lat_err_total = 0;
    int   v_err_total = 0;
    logic prev_vld = 1'b0;
    logic [7:0] prev_p = '0;
    always @(negedge clk) begin
        if (bus.sbox_tvalid) begin
            tv_total <= tv_total + 1;
            if (!prev_vld) lat_err_total <= lat_err_total + 1;
            if (bus.sbox_V !== prev_p) v_err_total <= v_err_total + 1;
        end
        prev_vld <= bus.chaos_valid;
        prev_p   <= cur_p;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] s);
        seed_in = s;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic measure_clear(output int low, output int loads);
        low = 0; loads = 0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.sbox_clr_n) low++;
            if (bus.chaos_load) loads++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !done; i++) @(negedge clk);
    endtask

    task automatic wait_first_tvalid();
        for (int i = 0; i < 400 && !bus.sbox_tvalid; i++) @(negedge clk);
    endtask

    task automatic wait_attempts(input logic [15:0] n);
        for (int i = 0; i < 1000 && attempts != n; i++) @(negedge clk);
    endtask

    int tv_base, lat_base, v_base, clr_low, loads;

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; seed_in = '0;
        repeat (3) @(negedge clk);
        check("rst_clr_n", bus.sbox_clr_n, 0);
        check("rst_busy", busy, 0);
        check("rst_req", bus.chaos_req, 0);
        check("rst_attempts", attempts, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_clr_n", bus.sbox_clr_n, 1);

        // Run 1: valid every cycle, full permutation expected
        tv_base = tv_total; lat_base = lat_err_total; v_base = v_err_total;
        do_start(32'h3A5F0C21);
        check("t1_seed", bus.chaos_seed, 32'h3A5F0C21);
        check("t1_busy", busy, 1);
        measure_clear(clr_low, loads);
        check("t1_clr_len", clr_low, 2);
        check("t1_load_cnt", loads, 1);
        wait_first_tvalid();
        check("t1_first_tvalid", bus.sbox_tvalid, 1);
        check("t1_first_V", bus.sbox_V, 8'hE1);
        wait_done(1000);
        check("t1_done", done, 1);
        check("t1_req_drop", bus.chaos_req, 0);
        check("t1_err", err, 0);
        check("t1_busy_end", busy, 0);
        @(negedge clk);
        check("t1_attempts", attempts, 257);
        check("t1_fwd_cnt", tv_total - tv_base, 257);
        check("t1_lat", lat_err_total - lat_base, 0);
        check("t1_vals", v_err_total - v_base, 0);

        // Run 2: constant sample, attempt limit
        gen_mode = 1;
        tv_base = tv_total;
        do_start(32'h11112222);
        for (int i = 0; i < 2000 && !err; i++) @(negedge clk);
        check("t2_err", err, 1);
        check("t2_done", done, 0);
        check("t2_req", bus.chaos_req, 0);
        check("t2_attempts", attempts, 300);
        repeat (3) @(negedge clk);
        check("t2_fwd_cnt", tv_total - tv_base, 300);
        check("t2_err_hold", err, 1);

        // Run 3: valid every 3rd cycle
        gen_mode = 0; gen_period = 3;
        tv_base = tv_total; lat_base = lat_err_total; v_base = v_err_total;
        do_start(32'hCAFE0001);
        check("t3_restart_err", err, 0);
        wait_done(3000);
        check("t3_done", done, 1);
        @(negedge clk);
        check("t3_attempts", attempts, 256);
        check("t3_fwd_cnt", tv_total - tv_base, 256);
        check("t3_lat", lat_err_total - lat_base, 0);
        check("t3_vals", v_err_total - v_base, 0);

        // Run 4: abort at attempt 100, then restart
        gen_period = 1;
        do_start(32'h0BADF00D);
        wait_attempts(16'd100);
        check("t4_reach100", attempts, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_req", bus.chaos_req, 0);
        check("t4_tvalid", bus.sbox_tvalid, 0);
        check("t4_clr_n", bus.sbox_clr_n, 1);
        check("t4_attempts", attempts, 100);
        @(negedge clk);
        check("t4_attempts_hold", attempts, 100);
        do_start(32'h0BADF00D);
        wait_done(1000);
        check("t4_redone", done, 1);
        check("t4_reattempts", attempts, 257);

        // Run 5: start in WARM ignored, start in DONE restarts with the new seed
        do_start(32'h12345678);
        repeat (10) @(negedge clk);
        seed_in = 32'hFFFF0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_warm_seed", bus.chaos_seed, 32'h12345678);
        check("t5_warm_clr_n", bus.sbox_clr_n, 1);
        check("t5_warm_load", bus.chaos_load, 0);
        check("t5_warm_busy", busy, 1);
        wait_done(1000);
        check("t5_done", done, 1);
        do_start(32'h87654399);
        check("t5_new_seed", bus.chaos_seed, 32'h87654399);
        check("t5_done_clr", done, 0);
        check("t5_att_zero", attempts, 0);
        measure_clear(clr_low, loads);
        check("t5_clr_len", clr_low, 2);
        check("t5_load_cnt", loads, 1);
        wait_first_tvalid();
        check("t5_first_V", bus.sbox_V, 8'h59);
        wait_done(1000);
        check("t5_redone", done, 1);

        // Run 6: asynchronous reset mid-GEN
        do_start(32'h55AA55AA);
        wait_attempts(16'd50);
        check("t6_reach50", attempts, 50);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_err", err, 0);
        check("t6_attempts", attempts, 0);
        check("t6_req", bus.chaos_req, 0);
        check("t6_load", bus.chaos_load, 0);
        check("t6_seed", bus.chaos_seed, 0);
        check("t6_clr_n", bus.sbox_clr_n, 0);
        check("t6_tvalid", bus.sbox_tvalid, 0);
        check("t6_V", bus.sbox_V, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_idle_clr_n", bus.sbox_clr_n, 1);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_req", bus.chaos_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
